// File: rtl/uncache_axi_bridge_pkg.sv
// ---------------------------------------------------------------------------
// uncache_axi_bridge_pkg
//   Shared definitions for the uncached-request to AXI4-Lite bridge:
//   one-hot FSM state encodings, AXI response codes, strobe width and a
//   small helper that classifies a response as an error.
// ---------------------------------------------------------------------------
package uncache_axi_bridge_pkg;

  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One-hot so each state decode is a single flop bit.
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_RD_ADDR = 6'b000010,
    ST_RD_DATA = 6'b000100,
    ST_WR_REQ  = 6'b001000,
    ST_WR_RESP = 6'b010000,
    ST_DONE    = 6'b100000
  } state_e;

  // Anything other than OKAY (SLVERR, DECERR, EXOKAY) is reported upstream.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/uncache_axi_bridge.sv
// ---------------------------------------------------------------------------
// uncache_axi_bridge
//   Turns one held uncached request into exactly one single-beat AXI4-Lite
//   read or write, then returns a one-cycle reload pulse carrying read data
//   and the response status. One transaction outstanding at a time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   axi_en/axi_wsel/axi_addr/axi_wdata
//                              request (held until reload; wsel==0 = read)
//   reload, axi_rdata, resp_err
//                              completion pulse, read data (held), error flag
//   m_ar*, m_r*                AXI4-Lite read address / read data channels
//   m_aw*, m_w*, m_b*          AXI4-Lite write address / data / response
// ---------------------------------------------------------------------------
module uncache_axi_bridge
  import uncache_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Requester side
  input  logic              axi_en,
  input  logic [STRB_W-1:0] axi_wsel,
  input  logic [ADDR_W-1:0] axi_addr,
  input  logic [DATA_W-1:0] axi_wdata,
  output logic              reload,
  output logic [DATA_W-1:0] axi_rdata,
  output logic              resp_err,
  // Read address channel
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  // Read data channel
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  // Write address channel
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  // Write data channel
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  // Write response channel
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   m_araddr_q,  m_araddr_d;
  logic                m_arvalid_q, m_arvalid_d;
  logic                m_rready_q,  m_rready_d;
  logic [ADDR_W-1:0]   m_awaddr_q,  m_awaddr_d;
  logic                m_awvalid_q, m_awvalid_d;
  logic [DATA_W-1:0]   m_wdata_q,   m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q,   m_wstrb_d;
  logic                m_wvalid_q,  m_wvalid_d;
  logic                m_bready_q,  m_bready_d;
  logic                aw_done_q,   aw_done_d;
  logic                w_done_q,    w_done_d;
  logic                err_q,       err_d;
  logic [DATA_W-1:0]   axi_rdata_q, axi_rdata_d;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = m_awvalid_q & m_awready;
  assign w_hs  = m_wvalid_q  & m_wready;

  // ---------------------------------------------------------------------
  // Next-state and output-register logic
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold-value default up front so no path
    // through the case statement can leave one unassigned (no latches).
    state_d     = state_q;
    m_araddr_d  = m_araddr_q;
    m_arvalid_d = m_arvalid_q;
    m_rready_d  = m_rready_q;
    m_awaddr_d  = m_awaddr_q;
    m_awvalid_d = m_awvalid_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    m_wvalid_d  = m_wvalid_q;
    m_bready_d  = m_bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    err_d       = err_q;
    axi_rdata_d = axi_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // The request is only looked at here; outside IDLE it is ignored.
        if (axi_en) begin
          if (axi_wsel == '0) begin
            m_araddr_d  = axi_addr;
            m_arvalid_d = 1'b1;
            state_d     = ST_RD_ADDR;
          end else begin
            m_awaddr_d  = axi_addr;
            m_wdata_d   = axi_wdata;
            m_wstrb_d   = axi_wsel;
            m_awvalid_d = 1'b1;
            m_wvalid_d  = 1'b1;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            state_d     = ST_WR_REQ;
          end
        end
      end

      ST_RD_ADDR: begin
        if (m_arvalid_q && m_arready) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
          state_d     = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (m_rready_q && m_rvalid) begin
          axi_rdata_d = m_rdata;
          err_d       = resp_is_err(m_rresp);
          m_rready_d  = 1'b0;
          state_d     = ST_DONE;
        end
      end

      ST_WR_REQ: begin
        // AW and W complete independently; a handshake seen this cycle
        // counts as done so a same-cycle pair still reaches WR_RESP at once.
        if (aw_hs) begin
          m_awvalid_d = 1'b0;
          aw_done_d   = 1'b1;
        end
        if (w_hs) begin
          m_wvalid_d = 1'b0;
          w_done_d   = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          m_bready_d = 1'b1;
          state_d    = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_bready_q && m_bvalid) begin
          err_d      = resp_is_err(m_bresp);
          m_bready_d = 1'b0;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      m_araddr_q  <= '0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      m_awaddr_q  <= '0;
      m_awvalid_q <= 1'b0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      m_wvalid_q  <= 1'b0;
      m_bready_q  <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      err_q       <= 1'b0;
      axi_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      m_araddr_q  <= m_araddr_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
      m_awaddr_q  <= m_awaddr_d;
      m_awvalid_q <= m_awvalid_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      m_wvalid_q  <= m_wvalid_d;
      m_bready_q  <= m_bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      err_q       <= err_d;
      axi_rdata_q <= axi_rdata_d;
    end
  end

  // reload is a straight decode of the one-hot DONE bit, so it is glitch
  // free and lasts exactly one cycle; resp_err is qualified by it.
  assign reload    = (state_q == ST_DONE);
  assign resp_err  = reload & err_q;
  assign axi_rdata = axi_rdata_q;

  assign m_araddr  = m_araddr_q;
  assign m_arvalid = m_arvalid_q;
  assign m_rready  = m_rready_q;
  assign m_awaddr  = m_awaddr_q;
  assign m_awvalid = m_awvalid_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign m_wvalid  = m_wvalid_q;
  assign m_bready  = m_bready_q;

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// ---------------------------------------------------------------------------
// tb_uncache_axi_bridge
//   Self-checking bench for uncache_axi_bridge. A bench-side AXI4-Lite slave
//   with per-channel delay knobs drives the master port; a behavioural model
//   tracks which channel obligations are outstanding and is compared with
//   the DUT every cycle. Directed scenarios pin exact latencies.
// ---------------------------------------------------------------------------
module tb_uncache_axi_bridge;

  logic        clk;
  logic        rst_n;
  logic        axi_en;
  logic [3:0]  axi_wsel;
  logic [31:0] axi_addr;
  logic [31:0] axi_wdata;
  logic        reload;
  logic [31:0] axi_rdata;
  logic        resp_err;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  uncache_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axi_en    (axi_en),
    .axi_wsel  (axi_wsel),
    .axi_addr  (axi_addr),
    .axi_wdata (axi_wdata),
    .reload    (reload),
    .axi_rdata (axi_rdata),
    .resp_err  (resp_err),
    .m_araddr  (m_araddr),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_awaddr  (m_awaddr),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // Scoreboard counters and the single comparison primitive
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: tracks which AXI obligations are open for the one
  // request in flight and predicts every output for the current cycle.
  // -------------------------------------------------------------------------
  logic        x_busy = 0, x_arv = 0, x_rr = 0, x_awv = 0, x_wv = 0, x_br = 0;
  logic        x_reload = 0, x_err = 0;
  logic [31:0] x_addr = 0, x_wdata = 0, x_rdata = 0;
  logic [3:0]  x_strb = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_busy <= 0; x_arv <= 0; x_rr <= 0; x_awv <= 0; x_wv <= 0; x_br <= 0;
      x_reload <= 0; x_err <= 0; x_rdata <= 0;
    end else if (x_reload) begin
      // Completion cycle: the bridge is back to accepting next cycle.
      x_reload <= 0;
      x_err    <= 0;
      x_busy   <= 0;
    end else if (!x_busy) begin
      if (axi_en) begin
        x_busy <= 1;
        x_addr <= axi_addr;
        if (axi_wsel == 4'd0) begin
          x_arv <= 1;
        end else begin
          x_awv   <= 1;
          x_wv    <= 1;
          x_wdata <= axi_wdata;
          x_strb  <= axi_wsel;
        end
      end
    end else if (x_arv) begin
      if (m_arready) begin
        x_arv <= 0;
        x_rr  <= 1;
      end
    end else if (x_rr) begin
      if (m_rvalid) begin
        x_rr     <= 0;
        x_rdata  <= m_rdata;
        x_err    <= (m_rresp != 2'b00);
        x_reload <= 1;
      end
    end else if (x_awv || x_wv) begin
      x_awv <= x_awv && !m_awready;
      x_wv  <= x_wv && !m_wready;
      x_br  <= !(x_awv && !m_awready) && !(x_wv && !m_wready);
    end else if (x_br) begin
      if (m_bvalid) begin
        x_br     <= 0;
        x_err    <= (m_bresp != 2'b00);
        x_reload <= 1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Compare process: every cycle, mid-cycle, DUT outputs against the model.
  // -------------------------------------------------------------------------
  int rl_count = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("reload",    reload,    x_reload);
      check("resp_err",  resp_err,  x_reload & x_err);
      check("arvalid",   m_arvalid, x_arv);
      check("rready",    m_rready,  x_rr);
      check("awvalid",   m_awvalid, x_awv);
      check("wvalid",    m_wvalid,  x_wv);
      check("bready",    m_bready,  x_br);
      check("axi_rdata", axi_rdata, x_rdata);
      if (x_arv) check("araddr", m_araddr, x_addr);
      if (x_awv) check("awaddr", m_awaddr, x_addr);
      if (x_wv) begin
        check("wdata", m_wdata, x_wdata);
        check("wstrb", m_wstrb, x_strb);
      end
      if (reload) rl_count++;
    end
  end

  // -------------------------------------------------------------------------
  // AXI4-Lite slave. Handshakes that will happen at the coming edge are
  // noted in p_* and retired at the following negedge.
  // -------------------------------------------------------------------------
  bit          rand_mode = 0;
  int          dir_ar_dly = 0, dir_aw_dly = 0, dir_w_dly = 0, dir_r_dly = 0, dir_b_dly = 0;
  logic [31:0] dir_rdata = 0;
  logic [1:0]  dir_rresp = 0, dir_bresp = 0;
  int          ar_hs_cnt = 0, aw_hs_cnt = 0;

  function automatic logic [1:0] pick_resp();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 2'b10;
    if (r == 1) return 2'b11;
    return 2'b00;
  endfunction

  initial begin
    bit p_ar, p_r, p_aw, p_w, p_b, rd_pend, wr_pend, aw_got, w_got;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    int ar_dly, aw_dly, w_dly, r_dly, b_dly;
    p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0;
    rd_pend = 0; wr_pend = 0; aw_got = 0; w_got = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0;
    m_arready = 0; m_awready = 0; m_wready = 0;
    m_rvalid = 0; m_bvalid = 0; m_rdata = 0; m_rresp = 0; m_bresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
        p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0;
        rd_pend = 0; wr_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      end else begin
        if (p_ar) begin rd_pend = 1; ar_hs_cnt++; end
        if (p_r)  m_rvalid = 0;
        if (p_aw) begin aw_got = 1; aw_hs_cnt++; end
        if (p_w)  w_got = 1;
        if (p_b)  m_bvalid = 0;
        if (aw_got && w_got) begin wr_pend = 1; aw_got = 0; w_got = 0; end

        if (m_arvalid) begin m_arready = (ar_cnt >= ar_dly); ar_cnt++; end
        else begin m_arready = 0; ar_cnt = 0; ar_dly = rand_mode ? int'($urandom_range(0, 3)) : dir_ar_dly; end
        if (m_awvalid) begin m_awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin m_awready = 0; aw_cnt = 0; aw_dly = rand_mode ? int'($urandom_range(0, 3)) : dir_aw_dly; end
        if (m_wvalid) begin m_wready = (w_cnt >= w_dly); w_cnt++; end
        else begin m_wready = 0; w_cnt = 0; w_dly = rand_mode ? int'($urandom_range(0, 3)) : dir_w_dly; end

        if (rd_pend && !m_rvalid) begin
          if (r_cnt >= r_dly) begin
            m_rvalid = 1;
            m_rdata  = rand_mode ? $urandom : dir_rdata;
            m_rresp  = rand_mode ? pick_resp() : dir_rresp;
            rd_pend  = 0;
            r_cnt    = 0;
          end else r_cnt++;
        end else if (!rd_pend) begin
          r_cnt = 0;
          r_dly = rand_mode ? int'($urandom_range(0, 3)) : dir_r_dly;
        end

        if (wr_pend && !m_bvalid) begin
          if (b_cnt >= b_dly) begin
            m_bvalid = 1;
            m_bresp  = rand_mode ? pick_resp() : dir_bresp;
            wr_pend  = 0;
            b_cnt    = 0;
          end else b_cnt++;
        end else if (!wr_pend) begin
          b_cnt = 0;
          b_dly = rand_mode ? int'($urandom_range(0, 3)) : dir_b_dly;
        end

        p_ar = m_arvalid && m_arready;
        p_r  = m_rvalid  && m_rready;
        p_aw = m_awvalid && m_awready;
        p_w  = m_wvalid  && m_wready;
        p_b  = m_bvalid  && m_bready;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Requester: raise a request, hold it until reload, drop it the cycle
  // after. Times are relative to the cycle axi_en first goes high (cycle 0).
  // -------------------------------------------------------------------------
  task automatic issue(input logic [3:0] wsel, input logic [31:0] addr, input logic [31:0] wdata,
                       output int t_arv, output int t_awdrop, output int t_wdrop, output int t_rl,
                       output logic [31:0] rd, output logic err, output logic [3:0] strb);
    int start, rel;
    bit seen_aw, seen_w, done;
    t_arv = -1; t_awdrop = -1; t_wdrop = -1; t_rl = -1;
    rd = 0; err = 0; strb = 0;
    seen_aw = 0; seen_w = 0; done = 0;
    @(negedge clk);
    axi_en = 1; axi_wsel = wsel; axi_addr = addr; axi_wdata = wdata;
    start = cyc;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      rel = cyc - start;
      if (m_arvalid && t_arv < 0) t_arv = rel;
      if (m_awvalid) seen_aw = 1;
      else if (seen_aw && t_awdrop < 0) t_awdrop = rel;
      if (m_wvalid) begin seen_w = 1; strb = m_wstrb; end
      else if (seen_w && t_wdrop < 0) t_wdrop = rel;
      if (reload) begin
        t_rl = rel; rd = axi_rdata; err = resp_err; done = 1;
      end
    end
    if (!done) check("reload_timeout", 0, 1);
    @(negedge clk);
    axi_en = 0;
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int ta, tad, twd, trl, rl0, ar0, aw0;
    logic [31:0] rd;
    logic err, got;
    logic [3:0] st;

    axi_en = 0; axi_wsel = 0; axi_addr = 0; axi_wdata = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    check("rst_reload",  reload,    0);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_wvalid",  m_wvalid,  0);
    check("rst_wstrb",   m_wstrb,   0);
    check("rst_rdata",   axi_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Read against an all-ready slave
    dir_rdata = 32'hDEAD_BEEF; dir_rresp = 2'b00;
    issue(4'b0000, 32'h1faf_fff0, 32'h0, ta, tad, twd, trl, rd, err, st);
    check("rd_arvalid_cyc", ta, 1);
    check("rd_reload_cyc", trl, 3);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_err", err, 0);

    // Write with AW held off two cycles and B returned two cycles late
    dir_aw_dly = 2; dir_b_dly = 2;
    issue(4'b0001, 32'h1fd0_03f8, 32'h41, ta, tad, twd, trl, rd, err, st);
    check("wr_wvalid_drop", twd, 2);
    check("wr_awvalid_drop", tad, 4);
    check("wr_reload_cyc", trl, 7);
    check("wr_strb", st, 4'b0001);
    check("wr_rdata_kept", rd, 32'hDEAD_BEEF);
    dir_aw_dly = 0; dir_b_dly = 0;

    // SLVERR read, then an OKAY read clears the flag
    dir_rresp = 2'b10; dir_rdata = 32'h0BAD_0001;
    issue(4'b0000, 32'h0000_0100, 32'h0, ta, tad, twd, trl, rd, err, st);
    check("slverr_flag", err, 1);
    check("slverr_data", rd, 32'h0BAD_0001);
    dir_rresp = 2'b00; dir_rdata = 32'h0000_1234;
    issue(4'b0000, 32'h0000_0104, 32'h0, ta, tad, twd, trl, rd, err, st);
    check("okay_flag", err, 0);
    check("okay_reload_cyc", trl, 3);

    // Asynchronous reset while waiting for read data
    dir_r_dly = 4;
    @(negedge clk);
    axi_en = 1; axi_wsel = 0; axi_addr = 32'h1000_0040;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (m_rready) got = 1;
    end
    check("rst_reached_rd_data", got, 1);
    #2 rst_n = 0; axi_en = 0;
    #1;
    check("mid_rst_rready",  m_rready,  0);
    check("mid_rst_arvalid", m_arvalid, 0);
    check("mid_rst_bready",  m_bready,  0);
    check("mid_rst_reload",  reload,    0);
    rl0 = rl_count;
    repeat (2) @(negedge clk);
    rst_n = 1;
    dir_r_dly = 0;
    repeat (8) @(negedge clk);
    check("no_reload_after_rst", rl_count, rl0);
    dir_rdata = 32'h5A5A_0001;
    issue(4'b0000, 32'h1000_0044, 32'h0, ta, tad, twd, trl, rd, err, st);
    check("post_rst_reload_cyc", trl, 3);
    check("post_rst_data", rd, 32'h5A5A_0001);

    // Write immediately followed by a read
    rl0 = rl_count; ar0 = ar_hs_cnt; aw0 = aw_hs_cnt;
    dir_rdata = 32'hCAFE_F00D;
    issue(4'b1100, 32'h2000_0008, 32'h1122_3344, ta, tad, twd, trl, rd, err, st);
    check("b2b_wr_rdata_kept", rd, 32'h5A5A_0001);
    check("b2b_wr_reload_cyc", trl, 3);
    issue(4'b0000, 32'h2000_000c, 32'h0, ta, tad, twd, trl, rd, err, st);
    check("b2b_rd_data", rd, 32'hCAFE_F00D);
    repeat (4) @(negedge clk);
    check("b2b_reloads", rl_count - rl0, 2);
    check("b2b_ar_count", ar_hs_cnt - ar0, 1);
    check("b2b_aw_count", aw_hs_cnt - aw0, 1);

    // Randomised traffic against random slave timing and responses
    rand_mode = 1;
    for (int i = 0; i < 80; i++) begin
      logic [3:0] ws;
      ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      issue(ws, $urandom, $urandom, ta, tad, twd, trl, rd, err, st);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
